seq_alu: RTL



---
 rtl/seq_alu.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative one-bit-per-cycle
// shifts, with a start/busy/done handshake and a persistent carry flag for multi-word ADC.
module seq_alu #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         use_cf,
    output logic [W-1:0] rslt,
    output logic         carry_out,
    output logic         taken,
    output logic         busy,
    output logic         done
);

    localparam int SHW = $clog2(W);

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ASR  = 4'b0001;
    localparam logic [3:0] OP_ADC  = 4'b0010;
    localparam logic [3:0] OP_NEG  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_ZERO = 4'b0101;
    localparam logic [3:0] OP_LSR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_CLRC = 4'b1000;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
    typedef enum logic [1:0] {SK_ASR, SK_LSR, SK_SHL} shift_e;

    state_e         state_q, state_d;
    shift_e         kind_q, kind_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [W-1:0]   rslt_q, rslt_d;
    logic           cf_q, cf_d;
    logic           taken_q, taken_d;
    logic           done_q, done_d;

    logic [W:0]     sum;
    logic [SHW-1:0] shamt;
    logic           is_shift;

    function automatic logic [W-1:0] shift1(input shift_e k, input logic [W-1:0] v);
        case (k)
            SK_ASR:  shift1 = {v[W-1], v[W-1:1]};
            SK_LSR:  shift1 = {1'b0, v[W-1:1]};
            default: shift1 = {v[W-2:0], 1'b0};
        endcase
    endfunction

    assign sum      = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, use_cf & cf_q};
    assign shamt    = in_b[SHW-1:0];
    assign is_shift = (op == OP_ASR) || (op == OP_LSR) || (op == OP_SHL);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rslt_d  = rslt_q;
        cf_d    = cf_q;
        taken_d = taken_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = in_a;
                        cnt_d   = shamt;
                        kind_d  = (op == OP_ASR) ? SK_ASR :
                                  (op == OP_LSR) ? SK_LSR : SK_SHL;
                        state_d = ST_SHIFT;
                    end else begin
                        done_d  = 1'b1;
                        rslt_d  = '0;
                        taken_d = 1'b0;
                        case (op)
                            OP_PASS:                 rslt_d = in_b;
                            OP_ASR, OP_LSR, OP_SHL:  rslt_d = in_a;   // zero-length shift
                            OP_ADC:                  {cf_d, rslt_d} = sum;
                            OP_NEG:                  taken_d = in_a[W-1];
                            OP_XOR:                  rslt_d = in_a ^ in_b;
                            OP_ZERO:                 taken_d = (in_a == '0);
                            OP_CLRC:                 cf_d = 1'b0;
                            default: ;
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = shift1(kind_q, acc_q);
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    rslt_d  = acc_d;
                    taken_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= SK_ASR;
            acc_q   <= '0;
            cnt_q   <= '0;
            rslt_q  <= '0;
            cf_q    <= 1'b0;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rslt_q  <= rslt_d;
            cf_q    <= cf_d;
            taken_q <= taken_d;
            done_q  <= done_d;
        end
    end

    assign rslt      = rslt_q;
    assign carry_out = cf_q;
    assign taken     = taken_q;
    assign done      = done_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule
